serial_deserializer: RTL and testbench

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/serial_deserializer_if.sv | 29 ++
 rtl/serial_deserializer.sv | 94 +++++++++
 tb/tb_serial_deserializer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/serial_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_deserializer_if
// Brief    : Serial-bit input and word-output bundle for serial_deserializer.
// Revision : 1.0
// ============================================================================
interface serial_deserializer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  bit_in;
    logic                  bit_valid;
    logic                  abort;
    logic [DATA_WIDTH-1:0] out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  overrun;

    modport master (
        output bit_in, bit_valid, abort, out_ready,
        input  out, out_valid, busy, overrun
    );

    modport slave (
        input  bit_in, bit_valid, abort, out_ready,
        output out, out_valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : serial_deserializer
// Brief    : Assembles a serial bit stream into DATA_WIDTH words with a
//            single-entry registered output, overrun flag and abort.
// Revision : 1.0
// ============================================================================
module serial_deserializer #(
    parameter int DATA_WIDTH = 16,
    parameter int LSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_deserializer_if.slave bus
);
    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_nx;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  busy_q, busy_d;
    logic                  accept;
    logic                  complete;

    // Whole-register shifts keep every bit of shift_q in use for either order.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign shift_nx = (shift_q >> 1)
                            | ({{(DATA_WIDTH-1){1'b0}}, bus.bit_in} << (DATA_WIDTH - 1));
        end else begin : g_msb_first
            assign shift_nx = (shift_q << 1) | {{(DATA_WIDTH-1){1'b0}}, bus.bit_in};
        end
    endgenerate

    assign accept   = bus.bit_valid & ~bus.abort;
    assign complete = accept & (cnt_q == LAST_CNT);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (bus.abort) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (bus.bit_valid) begin
            shift_d = shift_nx;
            cnt_d   = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // A completed word may only replace out when the slot is free or being drained.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        if (complete) begin
            if (!out_valid_q || bus.out_ready) begin
                out_d       = shift_nx;
                out_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_deserializer
// Brief    : Self-checking bench; LSB-first and MSB-first instances share stimulus.
// Revision : 1.0
// ============================================================================
module tb_serial_deserializer;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    serial_deserializer_if #(.DATA_WIDTH(DW)) if_l ();
    serial_deserializer_if #(.DATA_WIDTH(DW)) if_m ();

    serial_deserializer #(.DATA_WIDTH(DW), .LSB_FIRST(1)) u_dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l.slave)
    );

    serial_deserializer #(.DATA_WIDTH(DW), .LSB_FIRST(0)) u_dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index 0 = LSB-first, 1 = MSB-first; bits placed by arrival position.
    int          m_cnt   [2];
    logic [DW-1:0] m_acc [2];
    logic [DW-1:0] m_out [2];
    logic        m_valid [2];
    logic        m_ovr   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_acc[k] = '0; m_out[k] = '0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
        end
    endtask

    task automatic model_clock(input logic bv, input logic bi, input logic ab, input logic rdy);
        logic [DW-1:0] word;
        logic          done;
        int            pos;
        for (int k = 0; k < 2; k++) begin
            done = 1'b0;
            word = '0;
            if (ab) begin
                m_cnt[k] = 0;
                m_acc[k] = '0;
            end else if (bv) begin
                pos = (k == 0) ? m_cnt[k] : (DW - 1 - m_cnt[k]);
                m_acc[k][pos] = bi;
                m_cnt[k]++;
                if (m_cnt[k] == DW) begin
                    word = m_acc[k];
                    done = 1'b1;
                    m_cnt[k] = 0;
                    m_acc[k] = '0;
                end
            end
            m_ovr[k] = 1'b0;
            if (done) begin
                if (!m_valid[k] || rdy) begin
                    m_out[k]   = word;
                    m_valid[k] = 1'b1;
                end else begin
                    m_ovr[k] = 1'b1;
                end
            end else if (m_valid[k] && rdy) begin
                m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string pfx);
        check({pfx, "_out_l"},   32'(if_l.out),       32'(m_out[0]));
        check({pfx, "_vld_l"},   32'(if_l.out_valid), 32'(m_valid[0]));
        check({pfx, "_busy_l"},  32'(if_l.busy),      32'(m_cnt[0] != 0));
        check({pfx, "_ovr_l"},   32'(if_l.overrun),   32'(m_ovr[0]));
        check({pfx, "_out_m"},   32'(if_m.out),       32'(m_out[1]));
        check({pfx, "_vld_m"},   32'(if_m.out_valid), 32'(m_valid[1]));
        check({pfx, "_busy_m"},  32'(if_m.busy),      32'(m_cnt[1] != 0));
        check({pfx, "_ovr_m"},   32'(if_m.overrun),   32'(m_ovr[1]));
    endtask

    task automatic step(input logic bv, input logic bi, input logic ab, input logic rdy);
        if_l.bit_valid = bv; if_l.bit_in = bi; if_l.abort = ab; if_l.out_ready = rdy;
        if_m.bit_valid = bv; if_m.bit_in = bi; if_m.abort = ab; if_m.out_ready = rdy;
        @(posedge clk);
        model_clock(bv, bi, ab, rdy);
        #1;
        check_all("cyc");
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int max_gap, input logic rdy_last);
        for (int i = 0; i < DW; i++) begin
            for (int g = $urandom_range(max_gap, 0); g > 0; g--) step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b1, w[i], 1'b0, (i == DW - 1) ? rdy_last : 1'b0);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        if_l.bit_valid = 1'b0; if_l.bit_in = 1'b0; if_l.abort = 1'b0; if_l.out_ready = 1'b0;
        if_m.bit_valid = 1'b0; if_m.bit_in = 1'b0; if_m.abort = 1'b0; if_m.out_ready = 1'b0;
        model_reset();
        #12;
        check_all("rst");
        rst_n = 1'b1;

        // Bits 1,1,0,0,0,0,0,0 back to back
        send_word(8'h03, 0, 1'b0);
        check("w03_lsb", 32'(if_l.out), 32'h03);
        check("w03_msb", 32'(if_m.out), 32'hC0);
        check("w03_vld", 32'(if_l.out_valid), 32'h1);
        check("w03_busy", 32'(if_l.busy), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("drain_vld", 32'(if_m.out_valid), 32'h0);

        // Same pattern with 0-3 cycle gaps
        send_word(8'h03, 3, 1'b0);
        check("gap_msb", 32'(if_m.out), 32'hC0);
        check("gap_vld", 32'(if_m.out_valid), 32'h1);

        // Pending word blocks 0xFF: overrun pulse, out held
        send_word(8'hFF, 0, 1'b0);
        check("ovr_pulse", 32'(if_l.overrun), 32'h1);
        check("ovr_hold", 32'(if_l.out), 32'h03);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_clear", 32'(if_l.overrun), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_drain", 32'(if_l.out_valid), 32'h0);

        // Completion while the pending word is drained in the same cycle
        send_word(8'h03, 0, 1'b0);
        send_word(8'h5A, 1, 1'b1);
        check("swap_out", 32'(if_l.out), 32'h5A);
        check("swap_vld", 32'(if_l.out_valid), 32'h1);
        check("swap_ovr", 32'(if_l.overrun), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Abort after 4 bits, then a clean word
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("abort_busy", 32'(if_l.busy), 32'h0);
        send_word(8'h81, 0, 1'b0);
        check("abort_word", 32'(if_l.out), 32'h81);

        // Reset mid-word with a word pending
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        pulse_reset();
        send_word(8'hA5, 0, 1'b0);
        check("post_rst", 32'(if_l.out), 32'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic with occasional aborts and resets
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(99, 0) < 70) ? 1'b1 : 1'b0,
                 1'($urandom),
                 ($urandom_range(99, 0) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(99, 0) < 30) ? 1'b1 : 1'b0);
            if ($urandom_range(999, 0) < 3) pulse_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
